pipe_trace_buffer: RTL and testbench

Synthesizable on-chip trace capture for the MIPS datapath. Each clock it can record the pipeline snapshot: PC, rs/rt/rd register indices and the stall flag. It supports three capture modes: fill-to-full, ring buffer with PC-match trigger, and stall-filtered fill. The captured records are then drained oldest-first over a valid/ready port. It sits beside `datapath`, tapping `pc_val`, `rs`, `rt`, `rd` and `stall`, and replaces per-cycle simulation printing with hardware-visible trace.

---
 rtl/trace_pkg.sv | 27 ++
 rtl/trace_ram.sv | 26 ++
 rtl/pipe_trace_buffer.sv | 167 ++++++++++++++++
 tb/tb_pipe_trace_buffer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared types for the pipeline trace buffer: FSM states, capture modes and
// the record layout presented on rd_data.
package trace_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        POST    = 2'd2,
        DRAIN   = 2'd3
    } trace_state_t;

    localparam logic [1:0] MODE_FILL         = 2'd0;
    localparam logic [1:0] MODE_RING_TRIG    = 2'd1;
    localparam logic [1:0] MODE_FILL_NOSTALL = 2'd2;

    localparam int TRC_DATA_W = 32;
    localparam int TRC_REG_W  = 5;

    typedef struct packed {
        logic                 stall;
        logic [TRC_REG_W-1:0] rd;
        logic [TRC_REG_W-1:0] rt;
        logic [TRC_REG_W-1:0] rs;
        logic [TRC_DATA_W-1:0] pc_val;
    } trace_rec_t;

endpackage

// File: rtl/trace_ram.sv
// Trace record storage: one synchronous write port, one asynchronous
// (show-ahead) read port.
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 48
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Record write; contents are only meaningful below count, so no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/pipe_trace_buffer.sv
// On-chip pipeline trace capture with fill, ring-with-trigger and
// stall-filtered modes, drained oldest-first over a valid/ready port.
module pipe_trace_buffer
    import trace_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int DEPTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        arm,
    input  logic [1:0]                  mode,
    input  logic [DATA_W-1:0]           trig_pc,
    input  logic [$clog2(DEPTH)-1:0]    post_cnt,
    input  logic [DATA_W-1:0]           pc_val,
    input  logic [REG_W-1:0]            rs,
    input  logic [REG_W-1:0]            rt,
    input  logic [REG_W-1:0]            rd,
    input  logic                        stall,
    output logic                        rd_valid,
    input  logic                        rd_ready,
    output logic [DATA_W+3*REG_W:0]     rd_data,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        busy,
    output logic                        done
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int REC_W = DATA_W + 3*REG_W + 1;
    localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);

    trace_state_t      state_r, state_s;
    logic [1:0]        mode_r;
    logic [DATA_W-1:0] trig_pc_r;
    logic [PTR_W-1:0]  post_cnt_r;
    logic [PTR_W-1:0]  remaining_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              done_r;

    logic              wr_en_s;
    logic              pop_s;
    logic [CNT_W-1:0]  wr_cnt_s;
    logic [REC_W-1:0]  wr_rec_s;
    logic [REC_W-1:0]  ram_rdata_s;

    assign wr_rec_s = {stall, rd, rt, rs, pc_val};

    // Next-state, write-enable and pop decode.
    always_comb begin
        state_s  = state_r;
        wr_en_s  = 1'b0;
        pop_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (arm) state_s = CAPTURE;
                else     state_s = IDLE;
            end
            CAPTURE: begin
                wr_en_s = !((mode_r == MODE_FILL_NOSTALL) && stall);
                if (mode_r == MODE_RING_TRIG) begin
                    if (pc_val == trig_pc_r) begin
                        if (post_cnt_r == PTR_W'(0)) state_s = DRAIN;
                        else                         state_s = POST;
                    end else begin
                        state_s = CAPTURE;
                    end
                end else if (wr_en_s && (count_r == FULL_C - CNT_W'(1))) begin
                    state_s = DRAIN;
                end else begin
                    state_s = CAPTURE;
                end
            end
            POST: begin
                wr_en_s = 1'b1;
                if (remaining_r == PTR_W'(1)) state_s = DRAIN;
                else                          state_s = POST;
            end
            DRAIN: begin
                pop_s = rd_ready && (count_r != CNT_W'(0));
                if (pop_s && (count_r == CNT_W'(1))) state_s = IDLE;
                else                                 state_s = DRAIN;
            end
            default: state_s = IDLE;
        endcase
        // Ring capture saturates at DEPTH by overwriting the oldest record.
        if (wr_en_s) begin
            if (count_r == FULL_C) wr_cnt_s = count_r;
            else                   wr_cnt_s = count_r + CNT_W'(1);
        end else begin
            wr_cnt_s = count_r;
        end
    end

    // Control state, pointers and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            mode_r      <= 2'd0;
            trig_pc_r   <= '0;
            post_cnt_r  <= '0;
            remaining_r <= '0;
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            done_r      <= 1'b0;
        end else begin
            state_r <= state_s;
            case (state_r)
                IDLE: begin
                    if (arm) begin
                        mode_r     <= mode;
                        trig_pc_r  <= trig_pc;
                        post_cnt_r <= post_cnt;
                        wr_ptr_r   <= '0;
                        rd_ptr_r   <= '0;
                        count_r    <= '0;
                        done_r     <= 1'b0;
                    end
                end
                CAPTURE, POST: begin
                    if (wr_en_s) begin
                        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
                        count_r  <= wr_cnt_s;
                    end
                    if (state_r == CAPTURE) remaining_r <= post_cnt_r;
                    else                    remaining_r <= remaining_r - PTR_W'(1);
                    // A saturated ring has its oldest record at the next write slot.
                    if (state_s == DRAIN) begin
                        if (wr_cnt_s == FULL_C) rd_ptr_r <= wr_ptr_r + PTR_W'(1);
                        else                    rd_ptr_r <= '0;
                    end
                end
                DRAIN: begin
                    if (pop_s) begin
                        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
                        count_r  <= count_r - CNT_W'(1);
                    end
                    if (state_s == IDLE) done_r <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en_s),
        .waddr (wr_ptr_r),
        .wdata (wr_rec_s),
        .raddr (rd_ptr_r),
        .rdata (ram_rdata_s)
    );

    assign rd_valid = (state_r == DRAIN) && (count_r != CNT_W'(0));
    assign rd_data  = rd_valid ? ram_rdata_s : '0;
    assign count    = count_r;
    assign busy     = (state_r != IDLE);
    assign done     = done_r;

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Directed, table-driven bench for pipe_trace_buffer at DEPTH=8.
module tb_pipe_trace_buffer;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int DEPTH  = 8;
    localparam int REC_W  = DATA_W + 3*REG_W + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              arm = 1'b0;
    logic [1:0]        mode = 2'd0;
    logic [DATA_W-1:0] trig_pc = '0;
    logic [2:0]        post_cnt = 3'd0;
    logic [DATA_W-1:0] pc_val = '0;
    logic [REG_W-1:0]  rs = '0, rt = '0, rd = '0;
    logic              stall = 1'b0;
    logic              rd_valid;
    logic              rd_ready = 1'b0;
    logic [REC_W-1:0]  rd_data;
    logic [3:0]        count;
    logic              busy;
    logic              done;

    int n_cmp = 0;
    int n_bad = 0;

    pipe_trace_buffer #(.DATA_W(DATA_W), .REG_W(REG_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .mode(mode), .trig_pc(trig_pc),
        .post_cnt(post_cnt), .pc_val(pc_val), .rs(rs), .rt(rt), .rd(rd),
        .stall(stall), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_data(rd_data), .count(count), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  mode;
        logic [31:0] trig;
        logic [2:0]  post;
        bit          stall_odd;
        int          exp_n;
        logic [31:0] first_pc;
        logic [31:0] step;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Sample k of the traced pipeline: pc=4k, rs=k, rt=k+1, rd=k+2.
    task automatic drive(input int k, input bit so);
        logic [31:0] kv;
        kv     = k;
        pc_val = kv << 2;
        rs     = kv[4:0];
        rt     = kv[4:0] + 5'd1;
        rd     = kv[4:0] + 5'd2;
        stall  = so & kv[0];
    endtask

    function automatic logic [REC_W-1:0] exp_rec(input logic [31:0] pc, input bit so);
        logic [31:0] kv;
        kv = pc >> 2;
        return {so & kv[0], kv[4:0] + 5'd2, kv[4:0] + 5'd1, kv[4:0], pc};
    endfunction

    task automatic capture(input vec_t v);
        @(negedge clk);
        arm = 1'b1; mode = v.mode; trig_pc = v.trig; post_cnt = v.post;
        @(negedge clk);
        arm = 1'b0;
        chk({v.name, "_busy"}, {63'd0, busy}, 64'd1);
        drive(0, v.stall_odd);
        for (int k = 1; k < 100; k++) begin
            @(negedge clk);
            if (rd_valid) break;
            drive(k, v.stall_odd);
        end
        chk({v.name, "_valid"}, {63'd0, rd_valid}, 64'd1);
        chk({v.name, "_count"}, {60'd0, count}, 64'(v.exp_n));
    endtask

    task automatic drain(input vec_t v);
        for (int i = 0; i < v.exp_n; i++) begin
            chk({v.name, "_rv"}, {63'd0, rd_valid}, 64'd1);
            chk({v.name, "_rec"}, 64'(rd_data), 64'(exp_rec(v.first_pc + v.step * i, v.stall_odd)));
            rd_ready = 1'b1;
            @(negedge clk);
        end
        rd_ready = 1'b0;
        chk({v.name, "_end_rv"}, {63'd0, rd_valid}, 64'd0);
        chk({v.name, "_end_busy"}, {63'd0, busy}, 64'd0);
        chk({v.name, "_end_done"}, {63'd0, done}, 64'd1);
        chk({v.name, "_end_count"}, {60'd0, count}, 64'd0);
    endtask

    initial begin
        vec_t pv;
        vecs[0] = '{"fill",     2'd0, 32'h0,  3'd0, 1'b0, 8, 32'h00, 32'd4};
        vecs[1] = '{"nostall",  2'd2, 32'h0,  3'd0, 1'b1, 8, 32'h00, 32'd8};
        vecs[2] = '{"ring",     2'd1, 32'h40, 3'd3, 1'b0, 8, 32'h30, 32'd4};
        vecs[3] = '{"ringnw",   2'd1, 32'h04, 3'd0, 1'b0, 2, 32'h00, 32'd4};
        vecs[4] = '{"mode3",    2'd3, 32'h0,  3'd0, 1'b0, 8, 32'h00, 32'd4};

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_count", {60'd0, count}, 64'd0);
        chk("rst_busy",  {63'd0, busy}, 64'd0);
        chk("rst_rv",    {63'd0, rd_valid}, 64'd0);
        chk("rst_done",  {63'd0, done}, 64'd0);
        chk("rst_data",  64'(rd_data), 64'd0);
        rst_n = 1'b1;

        // Reset while in POST (trigger on first sample, post_cnt=5)
        @(negedge clk);
        arm = 1'b1; mode = 2'd1; trig_pc = 32'h0; post_cnt = 3'd5;
        @(negedge clk);
        arm = 1'b0; drive(0, 1'b0);
        @(negedge clk);
        drive(1, 1'b0);
        @(negedge clk);
        chk("post_count", {60'd0, count}, 64'd2);
        chk("post_busy", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rstpost_count", {60'd0, count}, 64'd0);
        chk("rstpost_busy", {63'd0, busy}, 64'd0);
        chk("rstpost_rv", {63'd0, rd_valid}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset while in DRAIN after one pop
        pv = vecs[3];
        pv.name = "rstdrain";
        capture(pv);
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
        chk("rstdrain_count1", {60'd0, count}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rstdrain_count", {60'd0, count}, 64'd0);
        chk("rstdrain_busy", {63'd0, busy}, 64'd0);
        chk("rstdrain_rv", {63'd0, rd_valid}, 64'd0);
        chk("rstdrain_done", {63'd0, done}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table of capture/drain scenarios
        foreach (vecs[i]) begin
            capture(vecs[i]);
            drain(vecs[i]);
        end

        // Drain under backpressure, with an ignored arm pulse
        begin
            int idx;
            bit prev_ready;
            logic [REC_W-1:0] prev_data;
            pv = vecs[0];
            pv.name = "bp";
            capture(pv);
            idx = 0;
            prev_ready = 1'b1;
            prev_data = '0;
            for (int cyc = 0; cyc < 200 && idx < DEPTH; cyc++) begin
                if (cyc == 2) arm = 1'b1;
                if (cyc == 3) begin
                    arm = 1'b0;
                    chk("bp_arm_busy", {63'd0, busy}, 64'd1);
                end
                chk("bp_rv", {63'd0, rd_valid}, 64'd1);
                if (!prev_ready) chk("bp_hold", 64'(rd_data), 64'(prev_data));
                chk("bp_rec", 64'(rd_data), 64'(exp_rec(32'(idx) * 32'd4, 1'b0)));
                rd_ready = (cyc % 3 == 1) ? 1'b0 : 1'($urandom_range(0, 1));
                prev_ready = rd_ready;
                prev_data = rd_data;
                if (rd_ready) idx++;
                @(negedge clk);
            end
            rd_ready = 1'b0;
            arm = 1'b0;
            chk("bp_popped", 64'(idx), 64'(DEPTH));
            chk("bp_done", {63'd0, done}, 64'd1);
            chk("bp_count", {60'd0, count}, 64'd0);
            chk("bp_rv_end", {63'd0, rd_valid}, 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
